card_dealer: RTL

Draws cards without replacement from a single 52-card deck, using the free-running 9-bit lfsr9 output as its random source. It consumes the LFSR stream, and the Blackjack hand/score logic consumes the cards it produces. One card is dealt per deal request, with a bounded latency. The block tracks the remaining cards and supports a reshuffle.

---
 rtl/blackjack_pkg.sv | 29 ++
 rtl/card_decode.sv | 20 ++
 rtl/card_dealer.sv | 90 +++++++++
 3 files changed

// File: rtl/blackjack_pkg.sv
// blackjack_pkg: deck constants, dealer states and card index decoding shared by the card blocks
package blackjack_pkg;

   localparam int DECK_SIZE = 52;
   localparam int SUIT_SIZE = 13;

   typedef enum logic [1:0] {IDLE, SAMPLE, PROBE} dealer_state_t;

   typedef struct packed {
      logic [1:0] suit;
      logic [3:0] rank;
   } card_t;

   // Repeated compare/subtract keeps the divide-by-13 cheap on a 6-bit index
   function automatic card_t idx_to_card(input logic [5:0] idx);
      card_t c;
      logic [5:0] r;
      r = idx;
      c.suit = 2'd0;
      for (int s = 0; s < 3; s++)
         if (r >= 6'(SUIT_SIZE)) begin
            r = r - 6'(SUIT_SIZE);
            c.suit = c.suit + 2'd1;
         end
      c.rank = 4'(r + 6'd1);
      return c;
   endfunction

endpackage

// File: rtl/card_decode.sv
// card_decode: maps a 0..51 card index to rank, suit and blackjack points (ace counts 1)
module card_decode
   import blackjack_pkg::*;
(
   input  logic [5:0] card_idx,
   output logic [3:0] rank,
   output logic [1:0] suit,
   output logic [3:0] points
);

   card_t c;

   always_comb begin
      c = idx_to_card(card_idx);
      rank = c.rank;
      suit = c.suit;
      points = (c.rank > 4'd10) ? 4'd10 : c.rank;
   end

endmodule

// File: rtl/card_dealer.sv
// card_dealer: deals cards without replacement from one 52-card deck using an external LFSR value,
// probing linearly from the random slot until an undealt card is found
module card_dealer
   import blackjack_pkg::*;
#(
   parameter int RND_W = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [RND_W-1:0] rnd,
   input  logic             deal_req,
   input  logic             shuffle,
   output logic             busy,
   output logic             card_valid,
   output logic [5:0]       card_idx,
   output logic [3:0]       rank,
   output logic [1:0]       suit,
   output logic [3:0]       points,
   output logic [5:0]       cards_left,
   output logic             deck_empty,
   output logic             err_empty
);

   localparam logic [5:0] DECK = 6'(DECK_SIZE);
   localparam logic [5:0] LAST = 6'(DECK_SIZE - 1);

   dealer_state_t state, next;
   logic [DECK_SIZE-1:0] used;
   logic [5:0] ptr, fold;
   logic hit, err_now;
   logic [3:0] dec_rank, dec_points;
   logic [1:0] dec_suit;
   logic unused_rnd;

   assign unused_rnd = ^rnd[RND_W-1:6];
   assign busy = (state != IDLE);
   assign deck_empty = (cards_left == 6'd0);

   card_decode u_decode (
      .card_idx(ptr),
      .rank    (dec_rank),
      .suit    (dec_suit),
      .points  (dec_points)
   );

   always_comb begin
      fold = (rnd[5:0] < DECK) ? rnd[5:0] : rnd[5:0] - DECK;
      hit = (state == PROBE) && !used[ptr] && !shuffle;
      err_now = (state == IDLE) && !shuffle && deal_req && deck_empty;
      next = shuffle ? IDLE :
             (state == IDLE) ? ((deal_req && !deck_empty) ? SAMPLE : IDLE) :
             (state == SAMPLE) ? PROBE :
             (state == PROBE && used[ptr]) ? PROBE : IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         used <= '0;
         ptr <= '0;
         cards_left <= DECK;
         card_valid <= 1'b0;
         err_empty <= 1'b0;
         card_idx <= '0;
         rank <= '0;
         suit <= '0;
         points <= '0;
      end else begin
         state <= next;
         card_valid <= hit;
         err_empty <= err_now;
         if (shuffle) begin
            used <= '0;
            cards_left <= DECK;
         end else if (hit) begin
            used[ptr] <= 1'b1;
            cards_left <= cards_left - 6'd1;
            card_idx <= ptr;
            rank <= dec_rank;
            suit <= dec_suit;
            points <= dec_points;
         end
         if (state == SAMPLE)
            ptr <= fold;
         else if (state == PROBE)
            ptr <= (ptr == LAST) ? 6'd0 : ptr + 6'd1;
      end
   end

endmodule
